// File: rtl/code_fetch.sv
// Fetch/decode front end for one CPU7 core: reads 14-bit code words at pcp and
// issues either an instruction pair or a literal of up to four extension words.
module code_fetch #(
   parameter logic [6:0] LIT_OP = 7'h7F,
   parameter int         ADDR_W = 28
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              core_en,
   input  logic              core_idle,
   input  logic [ADDR_W-1:0] pcp,
   output logic              pcp_step_en,
   output logic [13:0]       instr,
   output logic              instr_en,
   output logic [55:0]       push_value,
   output logic              push_en,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [13:0]       mem_rdata,
   output logic              busy
);

   // Memory handshake: mem_req stays high until a cycle in which mem_ack is
   // also high; that cycle transfers mem_rdata, and mem_ack may come in the
   // same cycle mem_req rises. Core pulses fire only in cycles with core_en=1.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_STEP   = 3'd2,
      S_DECODE = 3'd3,
      S_ISSUE  = 3'd4,
      S_DRAIN  = 3'd5,
      S_WAIT   = 3'd6
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [13:0] word_q;
   logic [55:0] acc_q;
   logic [2:0]  cnt_q;
   logic        ext_q;
   logic [13:0] instr_q;
   logic [55:0] push_q;
   logic        issue;
   logic        is_hdr;
   logic [2:0]  lit_n;
   logic        sx;
   logic [55:0] lit_value;

   assign is_hdr   = (word_q[6:0] == LIT_OP);
   assign lit_n    = {1'b0, word_q[8:7]} + 3'd1;
   assign sx       = word_q[9];
   assign mem_addr = pcp;
   assign busy     = (state_q != S_IDLE);

   // ext_q marks that word_q holds a literal header and acc_q is being filled.
   assign instr_en   = issue & ~ext_q;
   assign push_en    = issue & ext_q;
   assign instr      = instr_en ? word_q : instr_q;
   assign push_value = push_en ? lit_value : push_q;

   always_comb begin
      lit_value = acc_q;
      case (word_q[8:7])
         2'd0:    lit_value = {{42{sx & acc_q[13]}}, acc_q[13:0]};
         2'd1:    lit_value = {{28{sx & acc_q[27]}}, acc_q[27:0]};
         2'd2:    lit_value = {{14{sx & acc_q[41]}}, acc_q[41:0]};
         default: lit_value = acc_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      pcp_step_en = 1'b0;
      issue       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run && core_en && core_idle) state_d = S_REQ;
         end
         S_REQ: begin
            mem_req = 1'b1;
            if (mem_ack) state_d = S_STEP;
         end
         S_STEP: begin
            if (core_en) begin
               pcp_step_en = 1'b1;
               if (!ext_q)             state_d = S_DECODE;
               else if (cnt_q == 3'd1) state_d = S_ISSUE;
               else                    state_d = S_REQ;
            end
         end
         S_DECODE: begin
            state_d = is_hdr ? S_REQ : S_ISSUE;
         end
         S_ISSUE: begin
            if (core_en) begin
               issue   = 1'b1;
               state_d = S_DRAIN;
            end
         end
         // The core may still report idle in the cycle right after an issue.
         S_DRAIN: state_d = S_WAIT;
         S_WAIT: begin
            if (core_idle) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         ext_q   <= 1'b0;
         instr_q <= '0;
         push_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE) ext_q <= 1'b0;
         if (state_q == S_REQ && mem_ack) begin
            if (ext_q) acc_q  <= {acc_q[41:0], mem_rdata};
            else       word_q <= mem_rdata;
         end
         if (state_q == S_STEP && core_en && ext_q) cnt_q <= cnt_q - 3'd1;
         if (state_q == S_DECODE && is_hdr) begin
            cnt_q <= lit_n;
            acc_q <= '0;
            ext_q <= 1'b1;
         end
         if (instr_en) instr_q <= word_q;
         if (push_en)  push_q  <= lit_value;
      end
   end

endmodule

// File: tb/tb_code_fetch.sv
// Bench for code_fetch: memory and core models, table-driven items, stall,
// random and reset sequences, with an issue scoreboard.
module tb_code_fetch;
   localparam int ADDR_W = 28;

   logic              clk = 1'b0;
   logic              rst_n, run, core_en, core_idle;
   logic [ADDR_W-1:0] pcp;
   logic              pcp_step_en, instr_en, push_en, mem_req, mem_ack, busy;
   logic [13:0]       instr, mem_rdata;
   logic [55:0]       push_value;
   logic [ADDR_W-1:0] mem_addr;

   always #5 clk = ~clk;

   code_fetch dut (
      .clk(clk), .rst_n(rst_n), .run(run), .core_en(core_en), .core_idle(core_idle),
      .pcp(pcp), .pcp_step_en(pcp_step_en), .instr(instr), .instr_en(instr_en),
      .push_value(push_value), .push_en(push_en), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
   );

   typedef struct {
      logic [4:0][13:0] w;
      int               nw;
      int               delay;
      logic             lit;
      logic [55:0]      val;
   } vec_t;

   logic [13:0] mem [0:255];
   int          ack_delay = 0, wcnt = 0;
   logic        ack_block = 1'b0, ack_force = 1'b0;
   assign mem_ack   = ack_force | (mem_req & ~ack_block & (wcnt >= ack_delay));
   assign mem_rdata = mem[mem_addr[7:0]];

   int          checks = 0, errors = 0, cyc = 0, steps = 0;
   int          en_mode = 0, core_busy_len = 0, idle_cnt = 0;
   int          pre_cnt = 0, drop_cnt = 0;
   int          rise_cyc = 0, issue_cyc = 0;
   logic        seen_ack = 0, seen_step = 0, seen_pulse = 0;
   logic        last_req = 0, last_ack = 0, last_rst = 0, prev_busy = 0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [13:0] last_instr_exp = '0;
   logic [55:0] last_push_exp = '0;
   logic [56:0] exp_q[$];
   vec_t        vecs [9];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // One clock: sample/check at negedge, then drive models #1 after posedge.
   task automatic cycle();
      logic [56:0] got_v, exp_v;
      @(negedge clk);
      cyc++;
      if (instr_en || push_en) begin
         chk("pulse_rule", {62'd0, instr_en & push_en, ~core_en}, 64'd0);
         issue_cyc = cyc;
         got_v = push_en ? {1'b1, push_value} : {1'b0, 42'd0, instr};
         if (exp_q.size() == 0) chk("issue_unexpected", {7'd0, got_v}, 64'd0);
         else begin
            exp_v = exp_q.pop_front();
            chk("issue_value", {7'd0, got_v}, {7'd0, exp_v});
         end
      end
      if (pcp_step_en) begin
         steps++;
         chk("step_core_en", {63'd0, core_en}, 64'd1);
      end
      if (last_req && !last_ack && last_rst)
         chk("req_hold", {35'd0, mem_req, mem_addr}, {35'd0, 1'b1, last_addr});
      if (busy && !prev_busy) rise_cyc = cyc;
      seen_ack   = mem_ack & mem_req;
      seen_step  = pcp_step_en;
      seen_pulse = instr_en | push_en;
      last_req   = mem_req;
      last_ack   = mem_ack;
      last_addr  = mem_addr;
      last_rst   = rst_n;
      prev_busy  = busy;
      @(posedge clk);
      #1;
      ack_force = 1'b0;
      if (seen_step) pcp = pcp + 1;
      wcnt = (last_req && !last_ack) ? wcnt + 1 : 0;
      if (seen_pulse) idle_cnt = core_busy_len;
      else if (idle_cnt > 0) idle_cnt--;
      core_idle = (idle_cnt == 0);
      if (en_mode == 1) core_en = ($urandom_range(0, 99) >= 40);
      else if (en_mode == 2) begin
         if (seen_ack) begin pre_cnt = 0; drop_cnt = 2; end
         else if (seen_step) begin pre_cnt = 1; drop_cnt = 2; end
         if (pre_cnt > 0) begin core_en = 1'b1; pre_cnt--; end
         else if (drop_cnt > 0) begin core_en = 1'b0; drop_cnt--; end
         else core_en = 1'b1;
      end else core_en = 1'b1;
   endtask

   task automatic set_vec(input int i, input int nw, input int d, input logic lit,
                          input logic [55:0] val, input logic [13:0] w0, input logic [13:0] w1,
                          input logic [13:0] w2, input logic [13:0] w3, input logic [13:0] w4);
      vecs[i].w = {w4, w3, w2, w1, w0};
      vecs[i].nw = nw;
      vecs[i].delay = d;
      vecs[i].lit = lit;
      vecs[i].val = val;
   endtask

   function automatic logic [55:0] lit_model(input logic [4:0][13:0] w);
      logic [55:0] acc;
      int n, bits;
      acc = '0;
      n = int'(w[0][8:7]) + 1;
      bits = 14 * n;
      for (int i = 1; i <= n; i++) acc = (acc << 14) | {42'd0, w[i]};
      if (w[0][9] && n < 4 && acc[bits-1])
         for (int b = bits; b < 56; b++) acc[b] = 1'b1;
      return acc;
   endfunction

   task automatic run_item(input vec_t v, input bit check_lat);
      int start_steps, guard, n, lat_exp;
      for (int i = 0; i < v.nw; i++) mem[(int'(pcp) + i) % 256] = v.w[i];
      ack_delay = v.delay;
      exp_q.push_back({v.lit, v.val});
      if (v.lit) last_push_exp = v.val;
      else last_instr_exp = v.val[13:0];
      start_steps = steps;
      run = 1'b1;
      guard = 0;
      while (!busy && guard < 50) begin cycle(); guard++; end
      run = 1'b0;
      chk("start_timeout", {63'd0, busy}, 64'd1);
      guard = 0;
      while ((exp_q.size() != 0 || busy) && guard < 400) begin cycle(); guard++; end
      chk("done_timeout", {63'd0, guard >= 400}, 64'd0);
      exp_q.delete();
      chk("step_count", 64'(steps - start_steps), 64'(v.nw));
      if (check_lat) begin
         n = v.nw - 1;
         lat_exp = v.delay + 3 + (v.lit ? n * (v.delay + 2) : 0);
         chk("issue_latency", 64'(issue_cyc - rise_cyc), 64'(lat_exp));
      end
      repeat (3) begin
         cycle();
         chk("idle_quiet", {62'd0, mem_req, busy}, 64'd0);
      end
      chk("hold_instr", {50'd0, instr}, {50'd0, last_instr_exp});
      chk("hold_push", {8'd0, push_value}, {8'd0, last_push_exp});
   endtask

   initial begin
      vec_t rv;
      logic [13:0] w0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      set_vec(0, 1, 0, 1'b0, 56'h81,             14'h0081, 0, 0, 0, 0);
      set_vec(1, 3, 0, 1'b1, 56'h48345,          14'h00FF, 14'h0012, 14'h0345, 0, 0);
      set_vec(2, 2, 0, 1'b1, 56'hFFFFFFFFFFE000, 14'h027F, 14'h2000, 0, 0, 0);
      set_vec(3, 2, 1, 1'b1, 56'h2000,           14'h007F, 14'h2000, 0, 0, 0);
      set_vec(4, 5, 0, 1'b1, 56'hFFFC0000000001, 14'h01FF, 14'h3FFF, 0, 0, 14'h0001);
      set_vec(5, 1, 2, 1'b0, 56'h3F80,           14'h3F80, 0, 0, 0, 0);
      set_vec(6, 4, 0, 1'b1, 56'hFFFE0000000001, 14'h037F, 14'h2000, 0, 14'h0001, 0);
      set_vec(7, 2, 1, 1'b1, 56'h1234,           14'h3C7F, 14'h1234, 0, 0, 0);
      set_vec(8, 1, 0, 1'b0, 56'h3FFE,           14'h3FFE, 0, 0, 0, 0);

      rst_n = 1'b0; run = 1'b0; core_en = 1'b1; core_idle = 1'b1; pcp = '0;
      repeat (3) cycle();
      chk("rst_pulses", {59'd0, pcp_step_en, instr_en, push_en, mem_req, busy}, 64'd0);
      chk("rst_instr", {50'd0, instr}, 64'd0);
      chk("rst_push", {8'd0, push_value}, 64'd0);
      chk("rst_addr", {36'd0, mem_addr}, {36'd0, pcp});
      rst_n = 1'b1;
      cycle();

      for (int i = 0; i < 9; i++) begin
         core_busy_len = i % 3;
         run_item(vecs[i], 1'b1);
      end

      en_mode = 2;
      core_busy_len = 0;
      rv = vecs[5]; rv.delay = 3; run_item(rv, 1'b0);
      rv = vecs[1]; rv.delay = 3; run_item(rv, 1'b0);

      en_mode = 1;
      for (int k = 0; k < 20; k++) begin
         w0 = 14'($urandom_range(0, 16383));
         if (k % 2 == 1) w0[6:0] = 7'h7F;
         else if (w0[6:0] == 7'h7F) w0[0] = 1'b0;
         rv.w = {14'($urandom), 14'($urandom), 14'($urandom), 14'($urandom), w0};
         rv.lit = (k % 2 == 1);
         rv.nw = rv.lit ? int'(w0[8:7]) + 2 : 1;
         rv.val = rv.lit ? lit_model(rv.w) : {42'd0, w0};
         rv.delay = $urandom_range(0, 3);
         core_busy_len = $urandom_range(0, 4);
         run_item(rv, 1'b0);
      end

      en_mode = 0;
      core_busy_len = 0;
      mem[pcp[7:0]] = 14'h00FF;
      ack_block = 1'b1;
      run = 1'b1;
      for (int g = 0; g < 50 && !busy; g++) cycle();
      run = 1'b0;
      repeat (2) cycle();
      chk("req_before_rst", {63'd0, mem_req}, 64'd1);
      rst_n = 1'b0;
      cycle();
      chk("rst_mid_req", {62'd0, mem_req, busy}, 64'd0);
      chk("rst_mid_instr", {50'd0, instr}, 64'd0);
      chk("rst_mid_push", {8'd0, push_value}, 64'd0);
      last_instr_exp = '0;
      last_push_exp = '0;
      rst_n = 1'b1;
      ack_block = 1'b0;
      ack_force = 1'b1;
      repeat (4) begin
         cycle();
         chk("late_ack_ignored", {61'd0, mem_req, busy, pcp_step_en}, 64'd0);
      end
      run_item(vecs[0], 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
